int_to_float_seq: RTL

- Sequential encoder: converts a 16-bit two's-complement integer into the team's 13-bit float format (sign, 4-bit exp, 8-bit frac).
- Value = (-1)^sign × 0.frac × 2^exp. A result is normalised (frac[7]=1) unless it is zero.
- Producer side of the float path: its outputs feed the float comparator and other float consumers directly.
- Uses an iterative shift-left normaliser with a start/ready/done_tick handshake.

---
 rtl/int_to_float_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/int_to_float_seq.sv
`default_nettype none
// ============================================================================
// Module      : int_to_float_seq
// Description : Sequential 16-bit signed integer to 13-bit float encoder
//               (sign, 4-bit exponent, 8-bit fraction). It uses an iterative
//               shift-left normaliser behind a start/ready/done_tick handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_float_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] din,
    output logic        ready,
    output logic        done_tick,
    output logic        sign,
    output logic [3:0]  exp,
    output logic [7:0]  frac
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] C_E_START = 5'd16;

    state_t      r_state, w_state_next;
    logic [15:0] r_mag, w_mag_next;
    logic [4:0]  r_e, w_e_next;
    logic        r_s, w_s_next;
    logic        r_sign;
    logic [3:0]  r_exp;
    logic [7:0]  r_frac;

    logic [15:0] w_abs;
    logic        w_norm_end;
    logic        w_load;

    // The 16-bit unsigned magnitude keeps -32768 representable as 0x8000
    assign w_abs      = din[15] ? (~din + 16'd1) : din;
    assign w_norm_end = (r_mag == 16'd0) || r_mag[15];
    assign w_load     = (r_state == ST_NORM) && w_norm_end;

    assign ready     = (r_state == ST_IDLE);
    assign done_tick = (r_state == ST_DONE);
    assign sign      = r_sign;
    assign exp       = r_exp;
    assign frac      = r_frac;

    // State and normaliser datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mag   <= 16'd0;
            r_e     <= 5'd0;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mag   <= w_mag_next;
            r_e     <= w_e_next;
            r_s     <= w_s_next;
        end
    end

    // Next-state and normaliser datapath logic
    always_comb begin
        w_state_next = r_state;
        w_mag_next   = r_mag;
        w_e_next     = r_e;
        w_s_next     = r_s;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_s_next     = din[15];
                    w_mag_next   = w_abs;
                    w_e_next     = C_E_START;
                    w_state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                if (w_norm_end) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_mag_next = {r_mag[14:0], 1'b0};
                    w_e_next   = r_e - 5'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result registers load once per conversion; zero wins over saturation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_exp  <= 4'd0;
            r_frac <= 8'd0;
        end else if (w_load) begin
            if (r_mag == 16'd0) begin
                r_sign <= 1'b0;
                r_exp  <= 4'd0;
                r_frac <= 8'd0;
            end else if (r_e == C_E_START) begin
                r_sign <= 1'b1;
                r_exp  <= 4'hF;
                r_frac <= 8'hFF;
            end else begin
                r_sign <= r_s;
                r_exp  <= r_e[3:0];
                r_frac <= r_mag[15:8];
            end
        end
    end

endmodule
`default_nettype wire
